// File: rtl/mem_stage_ctrl.sv
// Memory stage controller: drives a req/ack data memory, stalls upstream while
// an access is outstanding, and holds the MEM/WB pipeline register.
module mem_stage_ctrl #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RegWrite_in,
  input  logic              MemWrite_in,
  input  logic              MemRead_in,
  input  logic              call_in,
  input  logic              mem_to_reg_in,
  input  logic [3:0]        reg_rd_in,
  input  logic [DATA_W-1:0] alu_result_in,
  input  logic [DATA_W-1:0] save_word_data_in,
  input  logic              ret_future_in,
  input  logic              HALT_in,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              stall_out,
  output logic              RegWrite_wb,
  output logic              call_wb,
  output logic              mem_to_reg_wb,
  output logic              ret_wb,
  output logic              HALT_wb,
  output logic [3:0]        reg_rd_wb,
  output logic [DATA_W-1:0] wb_data,
  output logic              mem_err,
  output logic              halted
);

  typedef enum logic {IDLE, WAIT} state_t;

  localparam logic [7:0] LIMIT = 8'(TIMEOUT - 1);

  state_t            state, state_nx;
  logic [7:0]        wait_cnt, wait_cnt_nx;
  logic              access;
  logic              abort;
  logic              use_mem;
  logic [DATA_W-1:0] rd_data;

  assign mem_we    = MemWrite_in;
  assign mem_addr  = alu_result_in;
  assign mem_wdata = save_word_data_in;
  assign access    = (MemRead_in | MemWrite_in) & ~halted;
  // A write takes priority over a simultaneous read, so only pure loads write back memory data.
  assign use_mem   = mem_to_reg_in & MemRead_in & ~MemWrite_in;
  assign rd_data   = abort ? '0 : mem_rdata;

  always_comb begin
    state_nx    = state;
    wait_cnt_nx = wait_cnt;
    mem_req     = 1'b0;
    stall_out   = 1'b0;
    abort       = 1'b0;
    case (state)
      IDLE: begin
        mem_req = access;
        if (access && !mem_ack) begin
          stall_out   = 1'b1;
          state_nx    = WAIT;
          wait_cnt_nx = '0;
        end
      end
      WAIT: begin
        mem_req   = 1'b1;
        stall_out = ~mem_ack;
        if (mem_ack) begin
          state_nx = IDLE;
        end else if (wait_cnt == LIMIT) begin
          // Ack has priority; the abort only fires when the last allowed cycle passes silently.
          abort     = 1'b1;
          stall_out = 1'b0;
          state_nx  = IDLE;
        end else begin
          wait_cnt_nx = wait_cnt + 8'd1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      wait_cnt      <= '0;
      RegWrite_wb   <= 1'b0;
      call_wb       <= 1'b0;
      mem_to_reg_wb <= 1'b0;
      ret_wb        <= 1'b0;
      HALT_wb       <= 1'b0;
      reg_rd_wb     <= '0;
      wb_data       <= '0;
      mem_err       <= 1'b0;
      halted        <= 1'b0;
    end else begin
      state    <= state_nx;
      wait_cnt <= wait_cnt_nx;
      if (abort) mem_err <= 1'b1;
      if (stall_out) begin
        RegWrite_wb   <= 1'b0;
        call_wb       <= 1'b0;
        mem_to_reg_wb <= 1'b0;
        ret_wb        <= 1'b0;
        HALT_wb       <= 1'b0;
      end else begin
        RegWrite_wb   <= RegWrite_in;
        call_wb       <= call_in;
        mem_to_reg_wb <= mem_to_reg_in;
        ret_wb        <= ret_future_in;
        HALT_wb       <= HALT_in;
        reg_rd_wb     <= reg_rd_in;
        wb_data       <= use_mem ? rd_data : alu_result_in;
        if (HALT_in) halted <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Bench for mem_stage_ctrl: single-cycle vector table plus hand-written
// wait/timeout/reset/halt sequences, with expected WB values queued per cycle.
module tb_mem_stage_ctrl;

  localparam int unsigned DATA_W  = 16;
  localparam int unsigned TIMEOUT = 15;

  logic              clk = 1'b0;
  logic              rst;
  logic              RegWrite_in, MemWrite_in, MemRead_in, call_in, mem_to_reg_in;
  logic [3:0]        reg_rd_in;
  logic [DATA_W-1:0] alu_result_in, save_word_data_in, mem_rdata;
  logic              ret_future_in, HALT_in, mem_ack;
  logic              mem_req, mem_we, stall_out;
  logic [DATA_W-1:0] mem_addr, mem_wdata, wb_data;
  logic              RegWrite_wb, call_wb, mem_to_reg_wb, ret_wb, HALT_wb;
  logic [3:0]        reg_rd_wb;
  logic              mem_err, halted;

  always #5 clk = ~clk;

  mem_stage_ctrl #(.DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .RegWrite_in(RegWrite_in), .MemWrite_in(MemWrite_in), .MemRead_in(MemRead_in),
    .call_in(call_in), .mem_to_reg_in(mem_to_reg_in), .reg_rd_in(reg_rd_in),
    .alu_result_in(alu_result_in), .save_word_data_in(save_word_data_in),
    .ret_future_in(ret_future_in), .HALT_in(HALT_in),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .stall_out(stall_out),
    .RegWrite_wb(RegWrite_wb), .call_wb(call_wb), .mem_to_reg_wb(mem_to_reg_wb),
    .ret_wb(ret_wb), .HALT_wb(HALT_wb), .reg_rd_wb(reg_rd_wb), .wb_data(wb_data),
    .mem_err(mem_err), .halted(halted)
  );

  typedef struct {
    logic        rw, call, m2r, ret, halt;
    logic [3:0]  rd;
    logic [15:0] data;
  } wb_t;

  typedef struct {
    logic        rw, mw, mr, call, m2r, ret, halt, ack;
    logic [3:0]  rd;
    logic [15:0] alu, wdata, rdata;
    logic        e_req, e_we, e_stall;
    wb_t         e_wb;
  } vec_t;

  int   n_checks = 0;
  int   n_fail   = 0;
  wb_t  sb_q[$];
  wb_t  last_wb;
  vec_t tbl[7];
  vec_t v;

  function automatic wb_t wbr(input logic rw, call, m2r, ret, halt,
                              input logic [3:0] rd, input logic [15:0] data);
    wb_t w;
    w.rw = rw; w.call = call; w.m2r = m2r; w.ret = ret; w.halt = halt;
    w.rd = rd; w.data = data;
    return w;
  endfunction

  function automatic vec_t mkv(input logic rw, mw, mr, call, m2r, ret, halt, ack,
                               input logic [3:0] rd, input logic [15:0] alu, wdata, rdata,
                               input logic e_req, e_we, e_stall, input wb_t e_wb);
    vec_t r;
    r.rw = rw; r.mw = mw; r.mr = mr; r.call = call; r.m2r = m2r; r.ret = ret;
    r.halt = halt; r.ack = ack; r.rd = rd; r.alu = alu; r.wdata = wdata; r.rdata = rdata;
    r.e_req = e_req; r.e_we = e_we; r.e_stall = e_stall; r.e_wb = e_wb;
    return r;
  endfunction

  function automatic vec_t nopv();
    return mkv(0,0,0,0,0,0,0,0, 4'd0, 16'h0, 16'h0, 16'h0, 0,0,0, wbr(0,0,0,0,0,4'd0,16'h0));
  endfunction

  function automatic wb_t bubble();
    return wbr(0,0,0,0,0, last_wb.rd, last_wb.data);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t d);
    RegWrite_in = d.rw; MemWrite_in = d.mw; MemRead_in = d.mr; call_in = d.call;
    mem_to_reg_in = d.m2r; ret_future_in = d.ret; HALT_in = d.halt; mem_ack = d.ack;
    reg_rd_in = d.rd; alu_result_in = d.alu; save_word_data_in = d.wdata; mem_rdata = d.rdata;
  endtask

  task automatic comb(input logic req, input logic we, input logic stall);
    #1;
    chk("mem_req", mem_req, req);
    chk("stall_out", stall_out, stall);
    chk("mem_addr", mem_addr, alu_result_in);
    chk("mem_wdata", mem_wdata, save_word_data_in);
    if (req) chk("mem_we", mem_we, we);
  endtask

  task automatic push(input wb_t w);
    sb_q.push_back(w);
    last_wb = w;
  endtask

  task automatic tick();
    wb_t e;
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard: got empty queue expected an entry");
    end else begin
      e = sb_q.pop_front();
      chk("RegWrite_wb", RegWrite_wb, e.rw);
      chk("call_wb", call_wb, e.call);
      chk("mem_to_reg_wb", mem_to_reg_wb, e.m2r);
      chk("ret_wb", ret_wb, e.ret);
      chk("HALT_wb", HALT_wb, e.halt);
      chk("reg_rd_wb", reg_rd_wb, e.rd);
      chk("wb_data", wb_data, e.data);
    end
  endtask

  task automatic nop_cycle();
    drive(nopv());
    comb(0, 0, 0);
    push(wbr(0,0,0,0,0,4'd0,16'h0));
    tick();
  endtask

  // Stalls for 'waits' cycles, then completes with ack (or times out when use_ack=0).
  task automatic wait_seq(input vec_t d, input int unsigned waits, input logic use_ack,
                          input wb_t final_wb);
    for (int unsigned k = 0; k < waits; k++) begin
      d.ack = 1'b0;
      drive(d);
      comb(1, d.mw, 1);
      push(bubble());
      tick();
    end
    d.ack = use_ack;
    drive(d);
    comb(1, d.mw, 0);
    push(final_wb);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected test completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tbl[0] = mkv(1,0,0,0,0,0,0,0, 4'd5,  16'h1234, 16'h0000, 16'h0000, 0,0,0, wbr(1,0,0,0,0,4'd5, 16'h1234));
    tbl[1] = mkv(1,0,1,0,1,0,0,1, 4'd3,  16'h0040, 16'h0000, 16'hBEEF, 1,0,0, wbr(1,0,1,0,0,4'd3, 16'hBEEF));
    tbl[2] = mkv(0,1,0,0,0,0,0,1, 4'd0,  16'h0020, 16'hA5A5, 16'h0000, 1,1,0, wbr(0,0,0,0,0,4'd0, 16'h0020));
    tbl[3] = mkv(0,1,1,0,1,0,0,1, 4'd2,  16'h0030, 16'h1357, 16'h7777, 1,1,0, wbr(0,0,1,0,0,4'd2, 16'h0030));
    tbl[4] = mkv(1,0,1,0,0,0,0,1, 4'd4,  16'h0050, 16'h0000, 16'h9999, 1,0,0, wbr(1,0,0,0,0,4'd4, 16'h0050));
    tbl[5] = mkv(1,0,0,1,0,1,0,0, 4'd15, 16'hFFFF, 16'h0000, 16'h0000, 0,0,0, wbr(1,1,0,1,0,4'd15,16'hFFFF));
    tbl[6] = mkv(0,0,0,0,1,0,0,1, 4'd6,  16'h0ABC, 16'h0000, 16'h1111, 0,0,0, wbr(0,0,1,0,0,4'd6, 16'h0ABC));

    rst = 1'b1;
    drive(nopv());
    repeat (2) @(posedge clk);
    #1;
    chk("rst_RegWrite_wb", RegWrite_wb, 0);
    chk("rst_HALT_wb", HALT_wb, 0);
    chk("rst_reg_rd_wb", reg_rd_wb, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_mem_err", mem_err, 0);
    chk("rst_halted", halted, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_stall", stall_out, 0);
    rst = 1'b0;
    last_wb = wbr(0,0,0,0,0,4'd0,16'h0);

    for (int i = 0; i < 7; i++) begin
      drive(tbl[i]);
      comb(tbl[i].e_req, tbl[i].e_we, tbl[i].e_stall);
      push(tbl[i].e_wb);
      tick();
    end

    // Load acknowledged after three stall cycles; bubbles keep rd/data of the previous op.
    v = mkv(1,0,1,0,1,0,0,0, 4'd7, 16'h0080, 16'h0000, 16'h00AA, 1,0,1, wbr(0,0,0,0,0,4'd0,16'h0));
    wait_seq(v, 3, 1'b1, wbr(1,0,1,0,0,4'd7,16'h00AA));
    nop_cycle();

    // Ack lands on the last allowed cycle: completes normally, no error.
    v = mkv(1,0,1,0,1,0,0,0, 4'd8, 16'h0090, 16'h0000, 16'h4242, 1,0,1, wbr(0,0,0,0,0,4'd0,16'h0));
    wait_seq(v, TIMEOUT, 1'b1, wbr(1,0,1,0,0,4'd8,16'h4242));
    chk("coincide_mem_err", mem_err, 0);
    nop_cycle();

    // Store that never gets an ack.
    v = mkv(0,1,0,0,0,0,0,0, 4'd0, 16'h0010, 16'h5555, 16'h0000, 1,1,1, wbr(0,0,0,0,0,4'd0,16'h0));
    wait_seq(v, TIMEOUT, 1'b0, wbr(0,0,0,0,0,4'd0,16'h0010));
    chk("timeout_mem_err", mem_err, 1);
    nop_cycle();
    nop_cycle();
    chk("sticky_mem_err", mem_err, 1);

    // Load that times out writes back zero instead of the bus value.
    v = mkv(1,0,1,0,1,0,0,0, 4'd10, 16'h00C0, 16'h0000, 16'hDEAD, 1,0,1, wbr(0,0,0,0,0,4'd0,16'h0));
    wait_seq(v, TIMEOUT, 1'b0, wbr(1,0,1,0,0,4'd10,16'h0000));
    chk("timeout_load_mem_err", mem_err, 1);
    nop_cycle();

    // Reset on the second WAIT cycle of a load.
    v = mkv(1,0,1,0,1,0,0,0, 4'd11, 16'h00D0, 16'h0000, 16'h0001, 1,0,1, wbr(0,0,0,0,0,4'd0,16'h0));
    for (int k = 0; k < 2; k++) begin
      drive(v);
      comb(1, 0, 1);
      push(bubble());
      tick();
    end
    drive(v);
    comb(1, 0, 1);
    rst = 1'b1;
    drive(nopv());
    push(wbr(0,0,0,0,0,4'd0,16'h0));
    tick();
    chk("rst_wait_mem_err", mem_err, 0);
    chk("rst_wait_halted", halted, 0);
    rst = 1'b0;
    v = nopv();
    v.ack = 1'b1;
    v.rdata = 16'hCAFE;
    drive(v);
    comb(0, 0, 0);
    push(wbr(0,0,0,0,0,4'd0,16'h0));
    tick();
    nop_cycle();

    // HALT reaches WB, after which memory requests are suppressed.
    v = nopv();
    v.halt = 1'b1;
    drive(v);
    comb(0, 0, 0);
    push(wbr(0,0,0,0,1,4'd0,16'h0));
    tick();
    chk("halted_set", halted, 1);
    v = mkv(1,0,1,0,1,0,0,0, 4'd9, 16'h0040, 16'h0000, 16'h0000, 0,0,0, wbr(0,0,0,0,0,4'd0,16'h0));
    drive(v);
    comb(0, 0, 0);
    push(wbr(1,0,1,0,0,4'd9,16'h0000));
    tick();
    v = mkv(0,1,0,0,0,0,0,1, 4'd1, 16'h0060, 16'h2222, 16'h0000, 0,0,0, wbr(0,0,0,0,0,4'd0,16'h0));
    drive(v);
    comb(0, 1, 0);
    push(wbr(0,0,0,0,0,4'd1,16'h0060));
    tick();
    chk("halted_sticky", halted, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
